// File: rtl/mram_array.sv
// mram_array: word-addressed MRAM array with byte lanes, a fixed access
// latency and a sticky read/write collision flag.
//
// Build option: MRAM_PARITY_EN adds one even-parity bit per byte lane plus
// the parity_err pulse. When it is undefined, par_inj is ignored and
// parity_err stays 0.
//
// Ports:
//   SIM_CLK, SIM_RST     clock (rising edge), asynchronous active-low reset
//   E_n, G_n, W_n        chip / read / write enables (active-low)
//   lane_n               byte-lane enables (active-low)
//   addr, wdata          word address and write data
//   par_inj              inverts the stored parity of enabled lanes on a write
//   ready                idle and able to accept a request
//   rdata, rdata_valid   read data (held between reads), one-cycle update pulse
//   err_collision        sticky; read and write were requested together
//   parity_err           pulses with rdata_valid on a parity mismatch
module mram_array #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 11,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  input  logic                    E_n,
  input  logic                    G_n,
  input  logic                    W_n,
  input  logic [DATA_WIDTH/8-1:0] lane_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    par_inj,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    err_collision,
  output logic                    parity_err
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]      lane_q, lane_d;
  logic                  inj_q, inj_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvld_q, rvld_d;
  logic                  coll_q, coll_d;
  logic                  perr_q, perr_d;

  // Single write port shared by the CLEAR sweep and write commits.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [LANES-1:0]      mem_be;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, rd_masked;
  logic [LANES-1:0]      par_bad;

  assign rd_word = mem_q[addr_q];

  // Disabled read lanes come back as zero.
  for (genvar i = 0; i < LANES; i++) begin : g_rmask
    assign rd_masked[8*i +: 8] = lane_q[i] ? 8'h00 : rd_word[8*i +: 8];
  end

`ifdef MRAM_PARITY_EN
  logic [LANES-1:0] par_mem_q [DEPTH];
  logic [LANES-1:0] mem_wp;
  logic [LANES-1:0] rd_par;

  assign rd_par = par_mem_q[addr_q];

  for (genvar i = 0; i < LANES; i++) begin : g_par
    // Even parity of the captured byte, optionally inverted for fault injection.
    assign mem_wp[i]  = (state_q == CLEAR) ? 1'b0 : ((^wdata_q[8*i +: 8]) ^ inj_q);
    assign par_bad[i] = !lane_q[i] && ((^rd_word[8*i +: 8]) != rd_par[i]);
  end

  always_ff @(posedge SIM_CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && mem_be[i]) par_mem_q[mem_wa][i] <= mem_wp[i];
    end
  end
`else
  logic unused_par;
  assign unused_par = inj_q;
  assign par_bad    = '0;
`endif

  always_ff @(posedge SIM_CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && mem_be[i]) mem_q[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    inj_d   = inj_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    coll_d  = coll_q;
    perr_d  = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = addr_q;
    mem_wd  = wdata_q;
    mem_be  = ~lane_q;
    case (state_q)
      CLEAR: begin
        mem_we  = 1'b1;
        mem_wa  = sweep_q;
        mem_wd  = '0;
        mem_be  = '1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (!E_n) begin
          if (!G_n && !W_n) begin
            coll_d = 1'b1;
          end else if (!G_n || !W_n) begin
            state_d = !G_n ? READ : WRITE;
            cnt_d   = CW'(ACCESS_CYCLES - 1);
            addr_d  = addr;
            wdata_d = wdata;
            lane_d  = lane_n;
            inj_d   = par_inj;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdata_d = rd_masked;
          rvld_d  = 1'b1;
          perr_d  = |par_bad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin // WRITE
        if (cnt_q == '0) begin
          state_d = IDLE;
          mem_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      inj_q   <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      coll_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      inj_q   <= inj_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      coll_q  <= coll_d;
      perr_q  <= perr_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign rdata         = rdata_q;
  assign rdata_valid   = rvld_q;
  assign err_collision = coll_q;
  assign parity_err    = perr_q;
endmodule

// File: doc/mram_array.md
# mram_array

Parametrised, clocked successor to the single-chip MRAM model: a synthesisable word-addressed MRAM array with configurable width, depth, and access time in clock cycles. It also provides per-byte lane enables, a ready/valid handshake, and a sticky collision flag that replaces the simulation-only abort. It sits behind the erasable/fixed memory interface logic and serves both simulation and FPGA targets with one behaviour.

## Interface
Parameters:
- DATA_WIDTH, 16: word width; must be a multiple of 8. LANES = DATA_WIDTH/8.
- ADDR_WIDTH, 11: depth is 2^ADDR_WIDTH words.
- ACCESS_CYCLES, 3: cycles from request accept to completion; must be >= 1.

Ports:
- SIM_CLK  in  1  single clock; all state changes on its rising edge.
- SIM_RST  in  1  reset; asynchronous, active-low.
- E_n  in  1  chip enable, active-low.
- G_n  in  1  output (read) enable, active-low.
- W_n  in  1  write enable, active-low.
- lane_n  in  LANES  byte-lane enables, active-low; bit i controls data bits [8i+7:8i].
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- par_inj  in  1  parity-fault injection; see Configuration.
- ready  out  1  array idle and able to accept a request.
- rdata  out  DATA_WIDTH  read data; holds its value until the next read completes.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- err_collision  out  1  sticky; set when a read and a write are requested together.
- parity_err  out  1  one-cycle pulse with rdata_valid on a parity mismatch.

## Operation
- States: CLEAR, IDLE, READ, WRITE.
- CLEAR: entered on reset. Writes zero to address 0 through 2^ADDR_WIDTH-1, one word per cycle, then goes to IDLE. ready=0 throughout.
- IDLE: ready=1. Decoding at a clock edge:
  - E_n=0, G_n=0, W_n=1: read request. Accept and go to READ.
  - E_n=0, W_n=0, G_n=1: write request. Accept and go to WRITE.
  - E_n=0, G_n=0, W_n=0: collision. Set err_collision, take no access, stay in IDLE.
  - Any other combination: no operation.
- On accept, addr, wdata, lane_n and par_inj are captured. Later changes to these inputs are ignored until the next accept.
- A down-counter is loaded with ACCESS_CYCLES-1 on accept and decrements once per cycle in READ or WRITE.
- READ completion (counter = 0):
  - rdata takes the stored word, with bytes whose lane is disabled forced to 0.
  - rdata_valid=1 for one cycle; return to IDLE.
- WRITE completion (counter = 0):
  - Only enabled lanes of the stored word are updated; disabled lanes keep their old value.
  - With all lanes disabled the write still takes its full time but changes nothing.
  - Return to IDLE.
- err_collision is cleared only by reset.
- A reset in any state, including mid-READ or mid-WRITE, aborts the access. The pending write is not committed and CLEAR restarts from address 0.

## Timing
- Reset values: ready=0, rdata=0, rdata_valid=0, err_collision=0, parity_err=0. State is CLEAR with sweep address 0.
- ready rises at edge 2^ADDR_WIDTH after reset release (the first edge clears address 0).
- Request accepted at edge k: ready=0 after edge k.
- At edge k+ACCESS_CYCLES: the write commits or rdata/rdata_valid update, and ready returns to 1.
- The earliest next accept is edge k+ACCESS_CYCLES+1, giving one access per ACCESS_CYCLES+1 cycles.
- A read accepted after a write completes returns the new data; there is no read-before-write hazard.
- The collision check is evaluated only in IDLE. Inputs are ignored while ready=0.

## Configuration
- MRAM_PARITY_EN defined:
  - Each byte lane stores one extra even-parity bit, computed from the written byte. If par_inj was captured high, the stored parity of enabled lanes is inverted.
  - CLEAR writes parity 0.
  - On read completion, parity_err pulses with rdata_valid if any enabled lane's stored parity mismatches.
- MRAM_PARITY_EN undefined:
  - No parity storage; parity_err is held at 0.
  - The par_inj port remains but is ignored.

## Test plan
- Reset sequence (ADDR_WIDTH=4, ACCESS_CYCLES=3): hold SIM_RST=0 and release. Required: ready rises after exactly 16 edges, and a read of every address returns 0x0000.
- Byte lanes: write 0xA5C3 with lane_n=00 to address 5, then write 0x1234 with lane_n=10. Required: read with lane_n=00 returns 0xA534; read with lane_n=01 returns 0xA500.
- Latency: accept a read at edge k with ACCESS_CYCLES=3. Required: rdata_valid=1 only in the cycle after edge k+3, ready=0 for edges k+1..k+2, and a new request presented at edge k+3 is not accepted.
- Collision: E_n=G_n=W_n=0 in IDLE. Required: err_collision=1 and stays 1 across later accesses, and memory is unchanged. Reset clears it.
- Reset mid-write: accept a write of 0xFFFF to address 2, then assert SIM_RST one cycle later. Required: after CLEAR, address 2 reads 0x0000.
- Parity (MRAM_PARITY_EN): write 0x00FF with par_inj=1 and lane_n=10, then read. Required: parity_err pulses with rdata_valid. Repeating the write with par_inj=0 gives parity_err=0.
